// File: rtl/sd_sector_writer.sv
// Packs a byte stream into 512-byte sectors and drives the sd_controller write handshake.
// Optional SD_SECTOR_CHECKSUM_EN adds a per-sector mod-2^16 byte sum output (sector_sum).
module sd_sector_writer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MAX_SECTORS = 1024,
  parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  input  logic        sd_ready,
  input  logic        sd_ready_for_next_byte,
  output logic        sd_wr,
  output logic [7:0]  sd_din,
  output logic [31:0] sd_addr,
  output logic        busy,
  output logic        full,
  output logic [15:0] sectors_done
`ifdef SD_SECTOR_CHECKSUM_EN
  ,
  output logic [15:0] sector_sum
`endif
);

  typedef enum logic [2:0] {
    S_FILL, S_PAD, S_WAIT_RDY, S_ISSUE, S_SEND, S_WAIT_DONE, S_FULL
  } state_t;

  state_t      state, state_next;
  logic [8:0]  fill_ptr;
  logic [8:0]  send_ptr;
  logic [7:0]  sector_buf [512];
  logic [7:0]  rd_data;
  logic        buf_we;
  logic [7:0]  buf_wdata;
  logic        send_adv;
  logic        sector_complete;
  logic [16:0] done_inc;
  logic        reach_max;

  assign done_inc  = {1'b0, sectors_done} + 17'd1;
  assign reach_max = {15'd0, done_inc} >= 32'(MAX_SECTORS);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next      = state;
    buf_we          = 1'b0;
    buf_wdata       = in_data;
    send_adv        = 1'b0;
    sector_complete = 1'b0;
    case (state)
      S_FILL: begin
        if (in_valid) begin
          buf_we = 1'b1;
          // The last byte of a sector wins over a coincident flush.
          if (fill_ptr == 9'd511)  state_next = S_WAIT_RDY;
          else if (flush)          state_next = S_PAD;
        end else if (flush && fill_ptr != 9'd0) begin
          state_next = S_PAD;
        end
      end
      S_PAD: begin
        buf_we    = 1'b1;
        buf_wdata = PAD_BYTE;
        if (fill_ptr == 9'd511) state_next = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (sd_ready) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (!sd_ready) state_next = S_SEND;
      end
      S_SEND: begin
        if (sd_ready_for_next_byte) begin
          send_adv = 1'b1;
          if (send_ptr == 9'd511) state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (sd_ready) begin
          sector_complete = 1'b1;
          state_next      = reach_max ? S_FULL : S_FILL;
        end
      end
      S_FULL:  state_next = S_FULL;
      default: state_next = S_FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state        <= S_FILL;
      fill_ptr     <= 9'd0;
      send_ptr     <= 9'd0;
      sd_addr      <= BASE_ADDR;
      sectors_done <= 16'd0;
    end else begin
      state <= state_next;
      if (buf_we)   fill_ptr <= fill_ptr + 9'd1;
      if (send_adv) send_ptr <= send_ptr + 9'd1;
      if (sector_complete) begin
        fill_ptr <= 9'd0;
        sd_addr  <= sd_addr + 32'd512;
        if (sectors_done != 16'hFFFF) sectors_done <= sectors_done + 16'd1;
      end
    end
  end

  // NOTE: the sector buffer has no reset; every byte is rewritten before it is ever sent.
  always_ff @(posedge clk_25mhz) begin
    if (buf_we) sector_buf[fill_ptr] <= buf_wdata;
    rd_data <= sector_buf[send_ptr];
  end

`ifdef SD_SECTOR_CHECKSUM_EN
  logic [15:0] run_sum;

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      run_sum    <= 16'd0;
      sector_sum <= 16'd0;
    end else if (sector_complete) begin
      sector_sum <= run_sum;
      run_sum    <= 16'd0;
    end else if (buf_we) begin
      run_sum <= run_sum + {8'd0, buf_wdata};
    end
  end
`endif

  assign in_ready = (state == S_FILL);
  assign busy     = (state != S_FILL);
  assign full     = (state == S_FULL);
  assign sd_wr    = (state == S_ISSUE);
  // send_ptr sits at 0 from WAIT_RDY on, so buf[0] is already in rd_data when ISSUE starts.
  assign sd_din   = (state == S_ISSUE || state == S_SEND) ? rd_data : 8'h00;

endmodule
